// File: rtl/pipe_stage_chain.sv
// Back-end register chain carrying one instruction slot through STAGES levels,
// with stall/flush control and saturating retire/ctrl/mispredict counters.

module pipe_stage_chain_level #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_stall,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (i_flush)       slot_d = '0;
    else if (!i_stall) slot_d = i_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign o_q = slot_q;
endmodule

module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_cnt_clr,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_pc_four,
  input  logic [DATA_W-1:0] i_pc_debug,
  input  logic [4:0]        i_rd_addr,
  input  logic              i_rdwren,
  input  logic [1:0]        i_wbsel,
  input  logic              i_ctrl,
  input  logic              i_mispred,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_alu,
  output logic [DATA_W-1:0] o_pc_four,
  output logic [DATA_W-1:0] o_pc_debug,
  output logic [4:0]        o_rd_addr,
  output logic              o_rdwren,
  output logic [1:0]        o_wbsel,
  output logic              o_ctrl,
  output logic              o_mispred,
  output logic [CNT_W-1:0]  o_retire_cnt,
  output logic [CNT_W-1:0]  o_ctrl_cnt,
  output logic [CNT_W-1:0]  o_mispred_cnt
);
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] pc_four;
    logic [DATA_W-1:0] pc_debug;
    logic [4:0]        rd_addr;
    logic              rdwren;
    logic [1:0]        wbsel;
    logic              ctrl;
    logic              mispred;
    logic              valid;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

  slot_t                in_slot;
  slot_t [STAGES-1:0]   slot_pipe;
  slot_t                out_slot;

  // Bubbles keep payload/rd as given but must never write or count as a branch.
  always_comb begin
    in_slot          = '0;
    in_slot.valid    = i_valid;
    in_slot.alu      = i_alu;
    in_slot.pc_four  = i_pc_four;
    in_slot.pc_debug = i_pc_debug;
    in_slot.rd_addr  = i_rd_addr;
    in_slot.wbsel    = i_wbsel;
    in_slot.rdwren   = i_valid & i_rdwren;
    in_slot.ctrl     = i_valid & i_ctrl;
    in_slot.mispred  = i_valid & i_mispred;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_lvl
    slot_t lvl_d;
    if (k == 0) begin : g_head
      assign lvl_d = in_slot;
    end else begin : g_body
      assign lvl_d = slot_pipe[k-1];
    end
    pipe_stage_chain_level #(.W(SLOT_W)) u_lvl (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_flush),
      .i_stall (i_stall),
      .i_d     (lvl_d),
      .o_q     (slot_pipe[k])
    );
  end

  assign out_slot = slot_pipe[STAGES-1];

  logic             retire_ev;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // A held output retires only on the edge it actually leaves the chain.
  assign retire_ev = out_slot.valid & ~i_stall & ~i_flush;

  always_comb begin
    retire_cnt_d  = retire_cnt_q;
    ctrl_cnt_d    = ctrl_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (i_cnt_clr) begin
      retire_cnt_d  = '0;
      ctrl_cnt_d    = '0;
      mispred_cnt_d = '0;
    end else if (retire_ev) begin
      if (retire_cnt_q != '1)
        retire_cnt_d = retire_cnt_q + 1'b1;
      if (out_slot.ctrl && ctrl_cnt_q != '1)
        ctrl_cnt_d = ctrl_cnt_q + 1'b1;
      if (out_slot.ctrl && out_slot.mispred && mispred_cnt_q != '1)
        mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      retire_cnt_q  <= '0;
      ctrl_cnt_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      retire_cnt_q  <= retire_cnt_d;
      ctrl_cnt_q    <= ctrl_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_valid       = out_slot.valid;
  assign o_alu         = out_slot.alu;
  assign o_pc_four     = out_slot.pc_four;
  assign o_pc_debug    = out_slot.pc_debug;
  assign o_rd_addr     = out_slot.rd_addr;
  assign o_rdwren      = out_slot.rdwren;
  assign o_wbsel       = out_slot.wbsel;
  assign o_ctrl        = out_slot.ctrl;
  assign o_mispred     = out_slot.mispred;
  assign o_retire_cnt  = retire_cnt_q;
  assign o_ctrl_cnt    = ctrl_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed + random bench for pipe_stage_chain (STAGES=3, CNT_W=4) against a
// queue-based reference model of the slot chain and saturating counters.

module tb_pipe_stage_chain;
  localparam int DATA_W = 32;
  localparam int STAGES = 3;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_stall, i_flush, i_cnt_clr, i_valid;
  logic [DATA_W-1:0] i_alu, i_pc_four, i_pc_debug;
  logic [4:0]        i_rd_addr;
  logic              i_rdwren, i_ctrl, i_mispred;
  logic [1:0]        i_wbsel;
  logic              o_valid, o_rdwren, o_ctrl, o_mispred;
  logic [DATA_W-1:0] o_alu, o_pc_four, o_pc_debug;
  logic [4:0]        o_rd_addr;
  logic [1:0]        o_wbsel;
  logic [CNT_W-1:0]  o_retire_cnt, o_ctrl_cnt, o_mispred_cnt;

  pipe_stage_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_cnt_clr(i_cnt_clr), .i_valid(i_valid), .i_alu(i_alu),
    .i_pc_four(i_pc_four), .i_pc_debug(i_pc_debug), .i_rd_addr(i_rd_addr),
    .i_rdwren(i_rdwren), .i_wbsel(i_wbsel), .i_ctrl(i_ctrl),
    .i_mispred(i_mispred), .o_valid(o_valid), .o_alu(o_alu),
    .o_pc_four(o_pc_four), .o_pc_debug(o_pc_debug), .o_rd_addr(o_rd_addr),
    .o_rdwren(o_rdwren), .o_wbsel(o_wbsel), .o_ctrl(o_ctrl),
    .o_mispred(o_mispred), .o_retire_cnt(o_retire_cnt),
    .o_ctrl_cnt(o_ctrl_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic              valid;
    logic [DATA_W-1:0] alu, pc_four, pc_debug;
    logic [4:0]        rd;
    logic              rdwren;
    logic [1:0]        wbsel;
    logic              ctrl, mispred;
  } m_slot_t;

  m_slot_t mq[$];
  int m_ret, m_ctrl, m_mis;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic m_slot_t bubble();
    m_slot_t s;
    s.valid = 0; s.alu = '0; s.pc_four = '0; s.pc_debug = '0; s.rd = '0;
    s.rdwren = 0; s.wbsel = '0; s.ctrl = 0; s.mispred = 0;
    return s;
  endfunction

  function automatic m_slot_t cur_in();
    m_slot_t s;
    s.valid = i_valid; s.alu = i_alu; s.pc_four = i_pc_four;
    s.pc_debug = i_pc_debug; s.rd = i_rd_addr; s.wbsel = i_wbsel;
    s.rdwren  = i_valid ? i_rdwren  : 1'b0;
    s.ctrl    = i_valid ? i_ctrl    : 1'b0;
    s.mispred = i_valid ? i_mispred : 1'b0;
    return s;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < STAGES; i++) mq.push_back(bubble());
    m_ret = 0; m_ctrl = 0; m_mis = 0;
  endtask

  task automatic model_edge();
    m_slot_t o = mq[STAGES-1];
    if (i_cnt_clr) begin
      m_ret = 0; m_ctrl = 0; m_mis = 0;
    end else if (o.valid && !i_stall && !i_flush) begin
      m_ret = sat_inc(m_ret);
      if (o.ctrl) m_ctrl = sat_inc(m_ctrl);
      if (o.ctrl && o.mispred) m_mis = sat_inc(m_mis);
    end
    if (i_flush) begin
      foreach (mq[i]) mq[i] = bubble();
    end else if (!i_stall) begin
      mq.push_front(cur_in());
      void'(mq.pop_back());
    end
  endtask

  task automatic chk_model();
    m_slot_t o = mq[STAGES-1];
    chk("valid",    32'(o_valid),      32'(o.valid));
    chk("alu",      o_alu,             o.alu);
    chk("pc_four",  o_pc_four,         o.pc_four);
    chk("pc_debug", o_pc_debug,        o.pc_debug);
    chk("rd_addr",  32'(o_rd_addr),    32'(o.rd));
    chk("rdwren",   32'(o_rdwren),     32'(o.rdwren));
    chk("wbsel",    32'(o_wbsel),      32'(o.wbsel));
    chk("ctrl",     32'(o_ctrl),       32'(o.ctrl));
    chk("mispred",  32'(o_mispred),    32'(o.mispred));
    chk("retire",   32'(o_retire_cnt), m_ret);
    chk("ctrlcnt",  32'(o_ctrl_cnt),   m_ctrl);
    chk("miscnt",   32'(o_mispred_cnt), m_mis);
    chk("invariant", 32'(o_mispred_cnt <= o_ctrl_cnt && o_ctrl_cnt <= o_retire_cnt), 32'd1);
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
    chk_model();
  endtask

  task automatic idle();
    i_stall = 0; i_flush = 0; i_cnt_clr = 0; i_valid = 0;
    i_alu = '0; i_pc_four = '0; i_pc_debug = '0; i_rd_addr = '0;
    i_rdwren = 0; i_wbsel = '0; i_ctrl = 0; i_mispred = 0;
  endtask

  task automatic set_slot(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                          input logic we, input logic c, input logic m);
    i_valid = v; i_alu = alu; i_rd_addr = rd; i_rdwren = we; i_ctrl = c; i_mispred = m;
    i_pc_four = $urandom; i_pc_debug = $urandom; i_wbsel = 2'($urandom_range(0, 3));
  endtask

  int r0;

  initial begin
    idle();
    model_reset();
    #1 i_rst = 1'b1;
    #2 chk_model();
    @(posedge i_clk); @(posedge i_clk);
    #3 i_rst = 1'b0;

    // T1: single slot emerges after exactly STAGES edges
    set_slot(1, 32'h0000_1234, 5'd5, 1, 0, 0);
    step();
    idle();
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) step();
      chk("t1_valid", 32'(o_valid), 32'(k == 3));
      if (k == 3) begin
        chk("t1_alu", o_alu, 32'h0000_1234);
        chk("t1_rd", 32'(o_rd_addr), 32'd5);
      end
    end
    chk("t1_retire", 32'(o_retire_cnt), 32'd1);

    // T2: stall holds output; counted once on release
    set_slot(1, 32'h0000_BEEF, 5'd9, 1, 1, 0);
    step();
    idle();
    step(); step();
    r0 = m_ret;
    i_stall = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_hold_alu", o_alu, 32'h0000_BEEF);
      chk("t2_hold_valid", 32'(o_valid), 32'd1);
      chk("t2_hold_retire", 32'(o_retire_cnt), r0);
    end
    i_stall = 0;
    step();
    chk("t2_release", 32'(o_retire_cnt), r0 + 1);
    step();
    chk("t2_once", 32'(o_retire_cnt), r0 + 1);

    // T3: flush beats stall with three valid slots in flight
    for (int k = 0; k < 3; k++) begin
      set_slot(1, 32'h100 + k, 5'(k + 1), 1, 1, 1);
      step();
    end
    r0 = m_ret;
    idle();
    i_flush = 1; i_stall = 1;
    step();
    chk("t3_valid", 32'(o_valid), 32'd0);
    chk("t3_rdwren", 32'(o_rdwren), 32'd0);
    chk("t3_retire", 32'(o_retire_cnt), r0);
    idle();
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t3_drain", 32'(o_valid), 32'd0);
      chk("t3_drain_cnt", 32'(o_retire_cnt), r0);
    end

    // T4: invalid slot carries payload but no side effects
    r0 = m_ret;
    set_slot(0, 32'h0000_ABCD, 5'd7, 1, 1, 1);
    step();
    idle();
    step(); step();
    chk("t4_valid", 32'(o_valid), 32'd0);
    chk("t4_rdwren", 32'(o_rdwren), 32'd0);
    chk("t4_ctrl", 32'(o_ctrl), 32'd0);
    chk("t4_alu", o_alu, 32'h0000_ABCD);
    step();
    chk("t4_cnt", 32'(o_retire_cnt), r0);

    // T5: saturation, then clear wins over a same-cycle retire
    for (int k = 0; k < 20; k++) begin
      set_slot(1, $urandom, 5'($urandom), 1, 1, 1);
      step();
    end
    idle();
    step(); step(); step();
    chk("t5_ret_sat", 32'(o_retire_cnt), CMAX);
    chk("t5_ctrl_sat", 32'(o_ctrl_cnt), CMAX);
    chk("t5_mis_sat", 32'(o_mispred_cnt), CMAX);
    set_slot(1, 32'h55, 5'd3, 1, 1, 1);
    step();
    idle();
    step(); step();
    chk("t5_pre_clr", 32'(o_valid), 32'd1);
    i_cnt_clr = 1;
    step();
    i_cnt_clr = 0;
    chk("t5_clr_ret", 32'(o_retire_cnt), 32'd0);
    chk("t5_clr_ctrl", 32'(o_ctrl_cnt), 32'd0);
    chk("t5_clr_mis", 32'(o_mispred_cnt), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      set_slot(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
      i_stall   = ($urandom_range(0, 7) == 0);
      i_flush   = ($urandom_range(0, 15) == 0);
      i_cnt_clr = ($urandom_range(0, 31) == 0);
      step();
    end

    // T6: async reset mid-stream, between edges
    idle();
    for (int k = 0; k < 2; k++) begin
      set_slot(1, 32'h77 + k, 5'd4, 1, 1, 0);
      step();
    end
    #2 i_rst = 1'b1;
    model_reset();
    #1;
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_alu", o_alu, 32'd0);
    chk("t6_retire", 32'(o_retire_cnt), 32'd0);
    chk_model();
    @(posedge i_clk);
    #3 i_rst = 1'b0;
    set_slot(1, 32'h0000_5A5A, 5'd6, 1, 0, 0);
    step();
    idle();
    chk("t6_lat1", 32'(o_valid), 32'd0);
    step();
    chk("t6_lat2", 32'(o_valid), 32'd0);
    step();
    chk("t6_lat3", 32'(o_valid), 32'd1);
    chk("t6_alu_out", o_alu, 32'h0000_5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
